// File: rtl/locked_sec_pipe.sv
// locked_sec_pipe: key-locked, two-stage pipelined Hamming SEC decoder.
// A serially loaded key {lut[3:0], in_mask, out_mask} masks the input data,
// masks the output data and replaces the syndrome bit-0 XOR with a 4-entry
// LUT. Only the correct key (lut = 4'b0110) decodes correctly.
// Optional feature: define ERR_CNT_EN to add the saturating err_cnt output.
// Ports:
//   clk, rst                  clock, async active-high reset
//   key_start/key_vld/key_bit serial key load, MSB first
//   armed                     key loaded, datapath enabled
//   in_valid/in_ready         input handshake for data_in/chk_in/chk_en
//   out_valid/out_ready       output handshake for data_out/err_corr/err_det
//   err_cnt                   corrected/detected word count (ERR_CNT_EN only)
module locked_sec_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CHK_W  = 6
`ifdef ERR_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_start,
  input  logic              key_vld,
  input  logic              key_bit,
  output logic              armed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CHK_W-1:0]  chk_in,
  input  logic              chk_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corr,
  output logic              err_det
`ifdef ERR_CNT_EN
  , output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned KEY_W  = 4 + 2 * DATA_W;
  localparam int unsigned KCNT_W = $clog2(KEY_W + 1);
  localparam int unsigned N_POS  = DATA_W + CHK_W;
  localparam int unsigned HALF   = DATA_W / 2;

  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

  state_t              state, state_nxt;
  logic [KEY_W-1:0]    key, key_nxt;
  logic [KCNT_W-1:0]   kcnt, kcnt_nxt;
  logic [3:0]          lut;
  logic [DATA_W-1:0]   in_mask, out_mask;

  logic                adv;
  logic [DATA_W-1:0]   d1;
  logic [CHK_W-1:0]    syn;
  logic                a, b;
  logic                s1_valid;
  logic [DATA_W-1:0]   s1_d;
  logic [CHK_W-1:0]    s1_s;
  logic [DATA_W-1:0]   fix;
  logic                corr, det;

  assign lut      = key[KEY_W-1 -: 4];
  assign in_mask  = key[2*DATA_W-1 -: DATA_W];
  assign out_mask = key[DATA_W-1:0];

  // 1-based codeword position of data bit idx (powers of two hold check bits)
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned n;
    data_pos = 0;
    n = 0;
    for (int unsigned p = 1; p <= N_POS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) data_pos = p;
        n++;
      end
    end
  endfunction

  // Key FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      key   <= '0;
      kcnt  <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      key   <= key_nxt;
      kcnt  <= kcnt_nxt;
      armed <= (state_nxt == ARMED);
    end
  end

  // Key FSM next state; key_start overrides any key bit in the same cycle
  always_comb begin
    state_nxt = state;
    key_nxt   = key;
    kcnt_nxt  = kcnt;
    if (key_start) begin
      state_nxt = LOAD;
      key_nxt   = '0;
      kcnt_nxt  = '0;
    end else begin
      case (state)
        LOAD: begin
          if (key_vld) begin
            key_nxt  = {key[KEY_W-2:0], key_bit};
            kcnt_nxt = kcnt + KCNT_W'(1);
            if (kcnt == KCNT_W'(KEY_W - 1)) state_nxt = ARMED;
          end
        end
        IDLE, ARMED: state_nxt = state;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Global stall: everything moves only when the output slot frees up
  assign adv      = !out_valid || out_ready;
  assign in_ready = armed && adv;

  // Stage 1 syndrome; bit 0 goes through the key LUT instead of an XOR
  always_comb begin
    d1  = data_in ^ in_mask;
    syn = '0;
    a   = 1'b0;
    b   = chk_in[0];
    for (int unsigned i = 0; i < DATA_W; i++) begin
      int unsigned p;
      p = data_pos(i);
      for (int unsigned j = 1; j < CHK_W; j++) begin
        if (p[j]) syn[j] = syn[j] ^ d1[i];
      end
      if (p[0]) begin
        if (i < HALF) a = a ^ d1[i];
        else          b = b ^ d1[i];
      end
    end
    for (int unsigned j = 1; j < CHK_W; j++) syn[j] = syn[j] ^ chk_in[j];
    syn[0] = lut[{a, b}];
    if (!chk_en) syn = '0;
  end

  // Stage 2 correction; check-bit syndromes match no data position, so data stays
  always_comb begin
    fix  = s1_d;
    corr = 1'b0;
    det  = 1'b0;
    if (s1_s != '0) begin
      if (32'(s1_s) > N_POS) begin
        det = 1'b1;
      end else begin
        corr = 1'b1;
        for (int unsigned i = 0; i < DATA_W; i++) begin
          if (data_pos(i) == 32'(s1_s)) fix[i] = ~s1_d[i];
        end
      end
    end
  end

  // Pipeline registers; key_start drops in-flight words, data_out keeps last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_d      <= '0;
      s1_s      <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      err_corr  <= 1'b0;
      err_det   <= 1'b0;
    end else if (key_start) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_d <= d1;
        s1_s <= syn;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= fix ^ out_mask;
        err_corr <= corr;
        err_det  <= det;
      end
    end
  end

`ifdef ERR_CNT_EN
  // Saturating count of delivered words carrying an error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (key_start) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && (err_corr || err_det) && !(&err_cnt)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_locked_sec_pipe.sv
// tb_locked_sec_pipe: directed and randomized checks of locked_sec_pipe
// against a codeword-level Hamming reference model and a scoreboard queue.
module tb_locked_sec_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned KW = 4 + 2 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_start, key_vld, key_bit;
  logic          armed;
  logic          in_valid, in_ready;
  logic [DW-1:0] data_in;
  logic [CW-1:0] chk_in;
  logic          chk_en;
  logic          out_valid, out_ready;
  logic [DW-1:0] data_out;
  logic          err_corr, err_det;
`ifdef ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  locked_sec_pipe #(.DATA_W(DW), .CHK_W(CW)) dut (
    .clk(clk), .rst(rst),
    .key_start(key_start), .key_vld(key_vld), .key_bit(key_bit), .armed(armed),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .chk_in(chk_in), .chk_en(chk_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err_corr(err_corr), .err_det(err_det)
`ifdef ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          c;
    logic          e;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  int   pos_of[DW];
  int   idx_of[64];
  logic [3:0]    m_lut;
  logic [DW-1:0] m_in, m_out;
  int   m_cnt = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check bits = XOR of positions of the set data bits (zero syndrome codeword)
  function automatic logic [CW-1:0] enc(input logic [DW-1:0] w);
    int x = 0;
    for (int i = 0; i < DW; i++) if (w[i]) x ^= pos_of[i];
    return x[CW-1:0];
  endfunction

  // Reference: syndrome is the XOR of the positions of all set codeword bits,
  // except bit 0 which comes from the key LUT.
  function automatic exp_t model(input logic [DW-1:0] din, input logic [CW-1:0] cin, input logic ce);
    logic [DW-1:0] d;
    int   syn;
    logic a, b;
    exp_t r;
    d   = din ^ m_in;
    syn = int'(cin);
    a   = 1'b0;
    b   = cin[0];
    for (int i = 0; i < DW; i++) begin
      if (d[i]) syn ^= pos_of[i];
      if (d[i] && (pos_of[i] % 2 == 1)) begin
        if (i < DW / 2) a = ~a;
        else            b = ~b;
      end
    end
    syn[0] = m_lut[{a, b}];
    if (!ce) syn = 0;
    r.d = d;
    r.c = 1'b0;
    r.e = 1'b0;
    if (syn != 0) begin
      if (syn > DW + CW) r.e = 1'b1;
      else begin
        r.c = 1'b1;
        if (idx_of[syn] >= 0) r.d[idx_of[syn]] = ~r.d[idx_of[syn]];
      end
    end
    r.d = r.d ^ m_out;
    return r;
  endfunction

  // Scoreboard: sampled mid-cycle, describes what the next rising edge does
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("sb_extra_word", 64'(q.size()), 1);
        else begin
          e = q.pop_front();
          check("sb_data", data_out, e.d);
          check("sb_corr", err_corr, e.c);
          check("sb_det", err_det, e.e);
          if ((e.c || e.e) && m_cnt < 65535) m_cnt++;
        end
      end
      if (key_start) begin
        q.delete();
        m_cnt = 0;
      end else if (in_valid && in_ready) begin
        q.push_back(model(data_in, chk_in, chk_en));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(3) != 0);
  end

  task automatic load_key(input logic [3:0] lut, input logic [DW-1:0] im, input logic [DW-1:0] om);
    logic [KW-1:0] k;
    int i;
    int n;
    k = {lut, im, om};
    key_start = 1'b1;
    @(posedge clk); #1;
    key_start = 1'b0;
    m_lut = lut; m_in = im; m_out = om;
    i = KW - 1;
    while (i >= 0) begin
      if ($urandom_range(3) == 0) key_vld = 1'b0;
      else begin
        key_vld = 1'b1;
        key_bit = k[i];
        i--;
      end
      @(posedge clk); #1;
    end
    key_vld = 1'b0;
    n = 0;
    while (!armed && n < 10) begin @(negedge clk); n++; end
    check("armed_after_load", armed, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ce);
    bit done = 1'b0;
    data_in = d; chk_in = c; chk_en = ce; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin done = 1'b1; break; end
    end
    if (!done) check("send_handshake", done, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 100) begin @(negedge clk); n++; end
    check("drain_empty", 64'(q.size()), 0);
`ifdef ERR_CNT_EN
    check("err_cnt", err_cnt, 64'(m_cnt));
`endif
    @(posedge clk); #1;
  endtask

  task automatic rand_phase(input int nwords, input bit rand_ce);
    rand_rdy = 1'b1;
    for (int k = 0; k < nwords; k++) begin
      logic [DW-1:0] w, din;
      logic [CW-1:0] c;
      logic ce;
      int ne;
      w = $urandom;
      c = enc(w);
      din = w ^ m_in;
      ne = $urandom_range(2);
      for (int e = 0; e < ne; e++) begin
        int bi = $urandom_range(DW + CW - 1);
        if (bi < DW) din[bi] = ~din[bi];
        else c[bi - DW] = ~c[bi - DW];
      end
      ce = rand_ce ? ($urandom_range(4) != 0) : 1'b1;
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
      send_word(din, c, ce);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w5 [3];
    int n = 0;
    for (int p = 0; p < 64; p++) idx_of[p] = -1;
    for (int p = 1; p <= DW + CW; p++) begin
      if ((p & (p - 1)) != 0) begin pos_of[n] = p; idx_of[p] = n; n++; end
    end
    m_lut = 4'b0; m_in = '0; m_out = '0;
    rst = 1'b1; key_start = 1'b0; key_vld = 1'b0; key_bit = 1'b0;
    in_valid = 1'b0; data_in = '0; chk_in = '0; chk_en = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_armed", armed, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_err", {err_corr, err_det}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: clean codeword, latency of two cycles
    load_key(4'b0110, '0, '0);
    send_word(32'hDEADBEEF, enc(32'hDEADBEEF), 1'b1);
    @(negedge clk); check("lat_one_cycle", out_valid, 0);
    @(negedge clk); check("lat_two_cycles", out_valid, 1);
    check("clean_data", data_out, 32'hDEADBEEF);
    check("clean_flags", {err_corr, err_det}, 0);
    @(posedge clk); #1;

    // 2: single-bit data error corrected; double error flagged
    send_word(32'hDEADBEEF ^ 32'h20, enc(32'hDEADBEEF), 1'b1);
    wait_out();
    check("sec_data", data_out, 32'hDEADBEEF);
    check("sec_corr", err_corr, 1);
    @(posedge clk); #1;
    send_word(32'hDEADBEEF ^ 32'h60, enc(32'hDEADBEEF), 1'b1);
    wait_out();
    check("dbl_flagged", err_corr | err_det, 1);
    check("dbl_not_clean", data_out == 32'hDEADBEEF, 0);
    @(posedge clk); #1;

    // 3: masked key; d recovers DEADBEEF, output carries the out_mask
    load_key(4'b0110, 32'hA5A5A5A5, 32'hA5A5A5A5);
    send_word(32'hDEADBEEF ^ 32'hA5A5A5A5, enc(32'hDEADBEEF), 1'b1);
    wait_out();
    check("mask_data", data_out ^ 32'hA5A5A5A5, 32'hDEADBEEF);
    check("mask_flags", {err_corr, err_det}, 0);
    @(posedge clk); #1;

    // 4: wrong LUT turns a clean codeword's zero bit-0 syndrome into 1
    load_key(4'b1001, '0, '0);
    send_word(32'hDEADBEEF, enc(32'hDEADBEEF), 1'b1);
    wait_out();
    check("badlut_corr", err_corr, 1);
    @(posedge clk); #1;
    drain();

    // 5: backpressure with three words offered
    load_key(4'b0110, $urandom, $urandom);
    for (int i = 0; i < 3; i++) w5[i] = $urandom;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) send_word(w5[i] ^ m_in, enc(w5[i]), 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // 6: key_start with two words in flight flushes the pipe
    out_ready = 1'b0;
    send_word(32'h12345678, enc(32'h12345678 ^ m_in), 1'b1);
    send_word(32'h9ABCDEF0, enc(32'h9ABCDEF0 ^ m_in), 1'b1);
    key_start = 1'b1;
    @(posedge clk); #1;
    key_start = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_armed", armed, 0);
`ifdef ERR_CNT_EN
    check("flush_err_cnt", err_cnt, 0);
`endif
    @(posedge clk); #1;
    out_ready = 1'b1;
    load_key(4'b0110, '0, '0);
    send_word(32'hCAFEF00D ^ 32'h1, enc(32'hCAFEF00D), 1'b1);
    wait_out();
    check("reload_data", data_out, 32'hCAFEF00D);
    @(posedge clk); #1;
    drain();

    // Randomized traffic: correct LUT, then a random LUT
    load_key(4'b0110, $urandom, $urandom);
    rand_phase(150, 1'b1);
    load_key(4'($urandom_range(15)), $urandom, $urandom);
    rand_phase(100, 1'b0);

    // Reset mid-stream
    out_ready = 1'b0;
    send_word(32'h0F0F0F0F ^ m_in, enc(32'h0F0F0F0F), 1'b1);
    send_word(32'hF0F0F0F0 ^ m_in, enc(32'hF0F0F0F0), 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_armed", armed, 0);
    check("midrst_data_out", data_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
